// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction front end: word width default,
// opcode encoding, fetch FSM states and a PC-width helper.
package isa_pkg;

  localparam int DEFAULT_INSTRUCTION_WIDTH = 32;

  // Major opcode field carried in the top bits of each instruction word.
  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_LOAD  = 6'd1,
    OP_STORE = 6'd2,
    OP_ADD   = 6'd3,
    OP_MUL   = 6'd4,
    OP_JUMP  = 6'd5,
    OP_BRZ   = 6'd6,
    OP_END   = 6'd63
  } opcode_t;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRAINED = 2'd2
  } fetch_state_t;

  // Width of a program counter able to index `count` instructions (at least 1).
  function automatic int pc_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Prefetch buffer: synchronous FIFO whose head entry is held in a register,
// so rd_data/rd_valid come straight from flops. flush empties it in one cycle.
module instr_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q;
  logic             valid_q;

  logic             push;
  logic             pop;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;

  // Next pointer/count and the word that will sit at the head after this edge.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path through the
    // block; a path that left one unassigned would infer a latch.
    push        = wr_en && (count_q != CW'(DEPTH));
    pop         = rd_en && (count_q != '0);
    rd_ptr_next = rd_ptr_q + AW'(pop);
    count_next  = count_q + CW'(push) - CW'(pop);
    // The slot being written becomes the head only when nothing older remains.
    head_next   = (push && (wr_ptr_q == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
  end

  // Storage array write port.
  // NOTE: the storage array is deliberately not reset; count/pointers say
  // which entries are meaningful, and leaving it reset-free lets it map to RAM.
  always_ff @(posedge clk_in) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_next;
      count_q  <= count_next;
      valid_q  <= (count_next != '0);
      if (count_next != '0) begin
        head_q <= head_next;
      end
    end
  end

  assign rd_data  = head_q;
  assign rd_valid = valid_q;
  assign count    = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues reads to a 2-cycle-latency instruction
// BRAM, tags each read with an epoch so redirects discard stale returns, and
// buffers returned words in a small FIFO feeding a valid/ready consumer.
module instruction_fetch
  import isa_pkg::*;
#(
  parameter  int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter  int INSTRUCTION_COUNT = 20,
  parameter  int FIFO_DEPTH        = 4,
  localparam int PW                = pc_width(INSTRUCTION_COUNT)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         stop_in,
  input  logic                         redirect_valid_in,
  input  logic [PW-1:0]                redirect_pc_in,
  output logic                         bram_en_out,
  output logic [PW-1:0]                bram_addr_out,
  input  logic [INSTRUCTION_WIDTH-1:0] bram_dout_in,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [PW-1:0]                instr_pc_out,
  output logic                         instr_valid_out,
  input  logic                         instr_ready_in,
  output logic                         busy_out,
  output logic                         error_out
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int            FW      = PW + INSTRUCTION_WIDTH;
  localparam logic [PW-1:0] LAST_PC = PW'(INSTRUCTION_COUNT - 1);
  localparam logic [31:0]   COUNT32 = 32'(INSTRUCTION_COUNT);

  fetch_state_t state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    epoch_q, epoch_d;
  logic          error_q, error_d;
  logic          flush;
  logic          issue;
  logic          credit_ok;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_pc_ext;

  // Two-deep record of reads in flight, matching the BRAM latency.
  logic          s1_valid_q, s2_valid_q;
  logic [1:0]    s1_epoch_q, s2_epoch_q;
  logic [PW-1:0] s1_pc_q, s2_pc_q;

  logic          fifo_wr;
  logic          fifo_rd;
  logic [FW-1:0] fifo_rd_data;
  logic          fifo_valid;
  logic [CW-1:0] fifo_count;

  assign redirect_pc_ext = {{(32-PW){1'b0}}, redirect_pc_in};

  // Buffered plus in-flight words; a read may issue only if it is sure to fit.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q} + {{CW{1'b0}}, s2_valid_q};
  assign credit_ok = (occupancy < (CW+1)'(FIFO_DEPTH));

  // Next-state, PC/epoch update and read issue; stop > start > redirect > fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    error_d = error_q;
    flush   = 1'b0;
    issue   = 1'b0;

    if (stop_in) begin
      state_d = IDLE;
      flush   = 1'b1;
      epoch_d = epoch_q + 2'd1;
    end else if (start_in) begin
      state_d = FETCH;
      pc_d    = '0;
      flush   = 1'b1;
      epoch_d = epoch_q + 2'd1;
    end else if (redirect_valid_in) begin
      flush   = 1'b1;
      epoch_d = epoch_q + 2'd1;
      if (redirect_pc_ext >= COUNT32) begin
        state_d = DRAINED;
        error_d = 1'b1;
      end else begin
        state_d = FETCH;
        pc_d    = redirect_pc_in;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (credit_ok) begin
            issue = 1'b1;
            pc_d  = pc_q + 1'b1;
            if (pc_q == LAST_PC) begin
              state_d = DRAINED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state, fetch PC, epoch and sticky error register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      pc_q    <= '0;
      epoch_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      error_q <= error_d;
    end
  end

  // In-flight shift register: stage 2 lines up with the BRAM data return.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_q <= 1'b0;
      s1_epoch_q <= '0;
      s1_pc_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_epoch_q <= '0;
      s2_pc_q    <= '0;
    end else begin
      s1_valid_q <= issue;
      s1_epoch_q <= epoch_q;
      s1_pc_q    <= pc_q;
      s2_valid_q <= s1_valid_q;
      s2_epoch_q <= s1_epoch_q;
      s2_pc_q    <= s1_pc_q;
    end
  end

  // Returning words from an older epoch, or arriving during a flush, are dropped.
  assign fifo_wr = s2_valid_q && (s2_epoch_q == epoch_q) && !flush;
  assign fifo_rd = fifo_valid && instr_ready_in;

  instr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush    (flush),
    .wr_en    (fifo_wr),
    .wr_data  ({s2_pc_q, bram_dout_in}),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_valid),
    .count    (fifo_count)
  );

  assign bram_en_out     = issue;
  assign bram_addr_out   = pc_q;
  assign instr_out       = fifo_rd_data[INSTRUCTION_WIDTH-1:0];
  assign instr_pc_out    = fifo_rd_data[INSTRUCTION_WIDTH +: PW];
  assign instr_valid_out = fifo_valid;
  assign busy_out        = (state_q != IDLE);
  assign error_out       = error_q;

endmodule
